instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of `cpu`. Takes the core's `pc_out` and returns the instruction at that address on `instr_bus`. Fetches over a valid/ack handshake from a variable-latency instruction memory. Holds a two-entry buffer (current + prefetched next word) and drives `stall` so the core holds `pc` while a fetch is outstanding.

## Interface
- `TIMEOUT`, 64: BUSY cycles without `imem_ack` before the request is abandoned as faulted.
- `NOP_INSTR`, 32'h0000_0013: word delivered on miss, fault, or reset (ADDI x0,x0,0).
- `clk`  in  1  core clock; all state on rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `pc_in`  in  32  address of the instruction to execute (core `pc_out`).
- `instr_bus`  out  32  instruction for `pc_in` (core `instr_bus`).
- `instr_valid`  out  1  `instr_bus` is the word at `pc_in`.
- `stall`  out  1  `~instr_valid`; the core must hold `pc` while high.
- `imem_req`  out  1  memory request, registered.
- `imem_addr`  out  32  request address, registered, word-aligned.
- `imem_ack`  in  1  request completes this cycle.
- `imem_rdata`  in  32  read data, sampled when `imem_ack`.
- `imem_err`  in  1  bus error, sampled when `imem_ack`.
- `fetch_fault`  out  1  sticky fault flag; cleared only by reset.
- `fault_addr`  out  32  address of the most recent fault.

## Operation
- Buffer entries: `cur` and `nxt`, each holding {valid, tag[31:0], data[31:0]}.
- Hit logic is combinational:
  - `hit_cur = cur.v && cur.tag==pc_in`.
  - `hit_nxt = nxt.v && nxt.tag==pc_in`.
  - `instr_valid = hit_cur | hit_nxt`.
  - `instr_bus` = `cur.data` if `hit_cur`, else `nxt.data` if `hit_nxt`, else `NOP_INSTR`.
- Promotion: on `hit_nxt && !hit_cur`, at the clock edge `cur <= nxt` and `nxt.v <= 0`.
- Flush: at each edge, invalidate any entry whose tag equals neither `pc_in` nor `pc_in+4`. This handles JAL, JALR and taken branches.
- `pc_in+4` is computed modulo 2^32, so 0xFFFF_FFFC wraps to 0.
- Target selection, in priority order:
  - Demand: `pc_in` if neither entry hits.
  - Prefetch: `pc_in+4` if it is not already held in `cur` or `nxt`.
  - Otherwise no target.
- FSM states:
  - IDLE: if a target exists, register `imem_req=1`, `imem_addr=target`, `req_addr=target`, and go to BUSY.
  - BUSY: hold `imem_req` and `imem_addr` stable. Increment `tcnt` each cycle.
- BUSY exits:
  - On `imem_ack`: drop `imem_req` at the edge, clear `tcnt`, return to IDLE.
  - On `tcnt==TIMEOUT-1` without ack: drop `imem_req` and treat as an error completion. The memory must abandon the transfer.
- Completion fill (ack or timeout):
  - Fill data is `imem_rdata`. It is `NOP_INSTR` if `imem_err` or timeout; in that case also set `fetch_fault` and load `fault_addr <= req_addr`.
  - If `req_addr==pc_in` (current cycle), write `cur`.
  - Else if `req_addr==pc_in+4`, write `nxt`.
  - Else discard as stale after a redirect. The fault is still recorded.
- Misaligned `pc_in` (bits[1:0]≠0): no request is issued.
  - `fetch_fault` is set and `fault_addr` is loaded with `pc_in`.
  - `cur` is loaded with tag `pc_in` and data `NOP_INSTR`, so the core proceeds past it.
- Simultaneous promotion and fill into `cur`: the fill wins. `nxt` is still cleared.

## Timing
- Reset values:
  - Outputs: `imem_req=0`, `imem_addr=0`, `fetch_fault=0`, `fault_addr=0`, `instr_valid=0`, `stall=1`, `instr_bus=NOP_INSTR`.
  - Internal: both entries invalid, state IDLE, `tcnt=0`.
- Assertion of `nreset` mid-transfer clears `imem_req` immediately (asynchronously). Any later ack is ignored because the FSM is in IDLE.
- Demand miss, cycle-by-cycle:
  - Miss seen in cycle 0.
  - `imem_req` high in cycle 1.
  - Ack in cycle k≥1.
  - `instr_valid` high in cycle k+1.
- Zero-wait memory (ack in the first request cycle): valid 2 cycles after the miss.
- Sequential stream: one request per 2 cycles minimum. The prefetch of `pc_in+4` starts in the first IDLE cycle after the demand fill.
- Hits, promotions and flushes add no cycles.

## Test plan
- Reset release with `pc_in=0x8000_0000` and 1-wait memory:
  - `imem_req` asserted at cycle 1 with `imem_addr=0x8000_0000`.
  - Ack at cycle 2 → `instr_valid=1` with the memory word at cycle 3.
  - Next request goes to 0x8000_0004.
- Sequential run of 8 words, 0-wait memory:
  - Every word delivered in order.
  - After each advance of `pc_in` to a prefetched address, `instr_valid` is high with no stall cycle.
- Redirect while a prefetch of 0x8000_0008 is outstanding, `pc_in` changed to 0x8000_0100:
  - Stale fill is discarded.
  - Next request goes to 0x8000_0100.
  - `instr_valid` stays low until that word arrives.
- `imem_err=1` on ack for 0x8000_0010:
  - `instr_bus=0x0000_0013`, `instr_valid=1`.
  - `fetch_fault=1`, `fault_addr=0x8000_0010`.
- Memory never acks:
  - After 64 BUSY cycles, `imem_req` drops.
  - Fault is recorded for the request address and a NOP is delivered.
- Misaligned and wrap cases:
  - `pc_in=0x8000_0002` → no request; NOP delivered; `fault_addr=0x8000_0002`.
  - `pc_in=0xFFFF_FFFC` → prefetch address is 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: two-entry buffer (current + prefetched next word)
// in front of a variable-latency valid/ack instruction memory.
module instr_fetch #(
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [31:0] pc_in,
    output logic [31:0] instr_bus,
    output logic        instr_valid,
    output logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        fetch_fault,
    output logic [31:0] fault_addr
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e state_q, state_d;

    logic          cur_v_q, cur_v_d;
    logic [31:0]   cur_tag_q, cur_tag_d;
    logic [31:0]   cur_data_q, cur_data_d;
    logic          nxt_v_q, nxt_v_d;
    logic [31:0]   nxt_tag_q, nxt_tag_d;
    logic [31:0]   nxt_data_q, nxt_data_d;

    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          fault_q, fault_d;
    logic [31:0]   faddr_q, faddr_d;

    logic [31:0]   pc_p4;
    logic          misaligned;
    logic          hit_cur;
    logic          hit_nxt;
    logic          held_p4;
    logic          demand;
    logic          prefetch;
    logic          have_tgt;
    logic [31:0]   target;
    logic          timed_out;
    logic          done;
    logic          bad;
    logic [31:0]   fill_data;
    logic          mis_miss;

    assign pc_p4      = pc_in + 32'd4;
    assign misaligned = (pc_in[1:0] != 2'b00);
    assign hit_cur    = cur_v_q && (cur_tag_q == pc_in);
    assign hit_nxt    = nxt_v_q && (nxt_tag_q == pc_in);
    assign held_p4    = (cur_v_q && (cur_tag_q == pc_p4))
                     || (nxt_v_q && (nxt_tag_q == pc_p4));

    // Misaligned PCs never reach memory; they are answered locally.
    assign demand     = !misaligned && !hit_cur && !hit_nxt;
    assign prefetch   = !misaligned && !held_p4;
    assign have_tgt   = demand || prefetch;
    assign target     = demand ? pc_in : pc_p4;
    assign mis_miss   = misaligned && !hit_cur && !hit_nxt;

    assign timed_out  = (state_q == S_BUSY) && !imem_ack
                     && (tcnt_q == TW'(TIMEOUT - 1));
    assign done       = (state_q == S_BUSY) && (imem_ack || timed_out);
    assign bad        = timed_out || (imem_ack && imem_err);
    assign fill_data  = bad ? NOP_INSTR : imem_rdata;

    assign instr_valid = hit_cur || hit_nxt;
    assign instr_bus   = hit_cur ? cur_data_q
                       : hit_nxt ? nxt_data_q
                       : NOP_INSTR;
    assign stall       = !instr_valid;

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign fetch_fault = fault_q;
    assign fault_addr  = faddr_q;

    // FSM state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: launch when a target exists, return on completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (have_tgt) state_d = S_BUSY;
            S_BUSY:  if (done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: request launch/hold/drop and the wait counter
    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        tcnt_d = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (have_tgt) begin
                    req_d  = 1'b1;
                    addr_d = target;
                    tcnt_d = '0;
                end
            end
            S_BUSY: begin
                if (done) begin
                    req_d  = 1'b0;
                    tcnt_d = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                req_d  = 1'b0;
                tcnt_d = '0;
            end
        endcase
    end

    // Buffer update: flush, promote, then fill (fill wins over promotion)
    always_comb begin
        cur_v_d    = cur_v_q;
        cur_tag_d  = cur_tag_q;
        cur_data_d = cur_data_q;
        nxt_v_d    = nxt_v_q;
        nxt_tag_d  = nxt_tag_q;
        nxt_data_d = nxt_data_q;
        if (cur_tag_q != pc_in && cur_tag_q != pc_p4) cur_v_d = 1'b0;
        if (nxt_tag_q != pc_in && nxt_tag_q != pc_p4) nxt_v_d = 1'b0;
        if (hit_nxt && !hit_cur) begin
            cur_v_d    = 1'b1;
            cur_tag_d  = nxt_tag_q;
            cur_data_d = nxt_data_q;
            nxt_v_d    = 1'b0;
        end
        if (done) begin
            if (addr_q == pc_in) begin
                cur_v_d    = 1'b1;
                cur_tag_d  = addr_q;
                cur_data_d = fill_data;
            end else if (addr_q == pc_p4) begin
                nxt_v_d    = 1'b1;
                nxt_tag_d  = addr_q;
                nxt_data_d = fill_data;
            end
        end
        if (mis_miss) begin
            cur_v_d    = 1'b1;
            cur_tag_d  = pc_in;
            cur_data_d = NOP_INSTR;
        end
    end

    // Sticky fault flag; stale faulted fills are still recorded
    always_comb begin
        fault_d = fault_q;
        faddr_d = faddr_q;
        if (done && bad) begin
            fault_d = 1'b1;
            faddr_d = addr_q;
        end
        if (mis_miss) begin
            fault_d = 1'b1;
            faddr_d = pc_in;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cur_v_q    <= 1'b0;
            cur_tag_q  <= '0;
            cur_data_q <= '0;
            nxt_v_q    <= 1'b0;
            nxt_tag_q  <= '0;
            nxt_data_q <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            tcnt_q     <= '0;
            fault_q    <= 1'b0;
            faddr_q    <= '0;
        end else begin
            cur_v_q    <= cur_v_d;
            cur_tag_q  <= cur_tag_d;
            cur_data_q <= cur_data_d;
            nxt_v_q    <= nxt_v_d;
            nxt_tag_q  <= nxt_tag_d;
            nxt_data_q <= nxt_data_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            tcnt_q     <= tcnt_d;
            fault_q    <= fault_d;
            faddr_q    <= faddr_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory responder, per-cycle
// model comparison and directed timing scenarios.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_bus;
    logic        instr_valid;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_err = 1'b0;
    logic        fetch_fault;
    logic [31:0] fault_addr;

    int total = 0;
    int passed = 0;

    int          mem_wait = 0;
    bit          err_en = 0;
    logic [31:0] err_addr = '0;
    bit          mem_hang = 0;
    int          wcnt = 0;

    always #5 clk = ~clk;

    instr_fetch #(.TIMEOUT(64), .NOP_INSTR(NOP)) dut (
        .clk(clk),
        .nreset(nreset),
        .pc_in(pc_in),
        .instr_bus(instr_bus),
        .instr_valid(instr_valid),
        .stall(stall),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .imem_err(imem_err),
        .fetch_fault(fetch_fault),
        .fault_addr(fault_addr)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Word the core must see at address a under the current memory setup.
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (a[1:0] != 2'b00 || mem_hang || (err_en && a == err_addr))
            return NOP;
        return memword(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory: acks after mem_wait request cycles unless hung.
    always @(posedge clk) begin
        #1;
        if (!nreset || !imem_req) begin
            imem_ack = 1'b0;
            imem_err = 1'b0;
            wcnt = 0;
        end else begin
            if (!mem_hang && wcnt >= mem_wait) begin
                imem_ack = 1'b1;
                imem_rdata = memword(imem_addr);
                imem_err = err_en && (imem_addr == err_addr);
            end else begin
                imem_ack = 1'b0;
                imem_err = 1'b0;
            end
            wcnt++;
        end
    end

    logic        prev_req = 1'b0;
    logic        prev_fault = 1'b0;
    logic [31:0] prev_addr = '0;

    // Per-cycle comparison against the memory-image model.
    always @(negedge clk) begin
        if (nreset) begin
            chk("stall", {31'b0, stall}, {31'b0, ~instr_valid});
            chk("bus", instr_bus, instr_valid ? exp_word(pc_in) : NOP);
            chk("align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (prev_fault) chk("sticky", {31'b0, fetch_fault}, 32'd1);
            if (prev_req && imem_req) chk("addr_hold", imem_addr, prev_addr);
            prev_req = imem_req;
            prev_addr = imem_addr;
            prev_fault = fetch_fault;
        end else begin
            prev_req = 1'b0;
            prev_fault = 1'b0;
        end
    end

    task automatic adv(input logic [31:0] pc);
        @(posedge clk);
        #1;
        pc_in = pc;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] pc, input bit chk_rst);
        @(posedge clk);
        #1;
        nreset = 1'b0;
        pc_in = pc;
        @(negedge clk);
        if (chk_rst) begin
            chk("rst_req", {31'b0, imem_req}, 32'd0);
            chk("rst_addr", imem_addr, 32'd0);
            chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
            chk("rst_faddr", fault_addr, 32'd0);
            chk("rst_valid", {31'b0, instr_valid}, 32'd0);
            chk("rst_stall", {31'b0, stall}, 32'd1);
            chk("rst_bus", instr_bus, NOP);
        end
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        bit found;
        logic [31:0] first_addr;
        logic [31:0] pc;

        // Reset release, 1-wait memory
        mem_wait = 1; err_en = 0; mem_hang = 0;
        do_reset(32'h8000_0000, 1);
        chk("s1_c0_req", {31'b0, imem_req}, 32'd0);
        adv(32'h8000_0000);
        chk("s1_c1_req", {31'b0, imem_req}, 32'd1);
        chk("s1_c1_addr", imem_addr, 32'h8000_0000);
        adv(32'h8000_0000);
        chk("s1_c2_valid", {31'b0, instr_valid}, 32'd0);
        adv(32'h8000_0000);
        chk("s1_c3_valid", {31'b0, instr_valid}, 32'd1);
        chk("s1_c3_bus", instr_bus, 32'hDA5A_C3C3);
        adv(32'h8000_0000);
        chk("s1_c4_req", {31'b0, imem_req}, 32'd1);
        chk("s1_c4_addr", imem_addr, 32'h8000_0004);

        // Sequential run of 8 words, 0-wait memory
        mem_wait = 0;
        do_reset(32'h8000_0000, 0);
        adv(32'h8000_0000);
        adv(32'h8000_0000);
        chk("s2_first_valid", {31'b0, instr_valid}, 32'd1);
        chk("s2_first_bus", instr_bus, memword(32'h8000_0000));
        pc = 32'h8000_0000;
        for (int i = 1; i < 8; i++) begin
            adv(pc);
            adv(pc);
            pc = pc + 32'd4;
            adv(pc);
            chk("s2_seq_valid", {31'b0, instr_valid}, 32'd1);
            chk("s2_seq_bus", instr_bus, memword(pc));
        end
        chk("s2_last_bus", instr_bus, 32'hDA5A_C3DF);

        // Redirect while prefetch of 0x8000_0008 is outstanding
        mem_wait = 3;
        do_reset(32'h8000_0004, 0);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == 32'h8000_0008) begin
                found = 1;
                break;
            end
            adv(32'h8000_0004);
        end
        chk("s3_pf_seen", {31'b0, found}, 32'd1);
        adv(32'h8000_0100);
        n = 0;
        first_addr = '0;
        while (!instr_valid && n < 40) begin
            if (imem_req && imem_addr != 32'h8000_0008 && first_addr == '0)
                first_addr = imem_addr;
            adv(32'h8000_0100);
            n++;
        end
        chk("s3_first_req", first_addr, 32'h8000_0100);
        chk("s3_invalid_cycles", n, 32'd8);
        chk("s3_bus", instr_bus, 32'hDA5A_C2C3);

        // Bus error on 0x8000_0010
        mem_wait = 0; err_en = 1; err_addr = 32'h8000_0010;
        do_reset(32'h8000_0010, 0);
        adv(32'h8000_0010);
        chk("s4_c1_fault", {31'b0, fetch_fault}, 32'd0);
        adv(32'h8000_0010);
        chk("s4_valid", {31'b0, instr_valid}, 32'd1);
        chk("s4_bus", instr_bus, 32'h0000_0013);
        chk("s4_fault", {31'b0, fetch_fault}, 32'd1);
        chk("s4_faddr", fault_addr, 32'h8000_0010);
        repeat (3) adv(32'h8000_0010);
        chk("s4_fault_kept", {31'b0, fetch_fault}, 32'd1);

        // Memory never acks
        err_en = 0; mem_hang = 1;
        do_reset(32'h8000_0000, 0);
        adv(32'h8000_0000);
        n = 0;
        while (imem_req && n < 100) begin
            n++;
            adv(32'h8000_0000);
        end
        chk("s5_busy_cycles", n, 32'd64);
        chk("s5_req_drop", {31'b0, imem_req}, 32'd0);
        chk("s5_valid", {31'b0, instr_valid}, 32'd1);
        chk("s5_bus", instr_bus, NOP);
        chk("s5_fault", {31'b0, fetch_fault}, 32'd1);
        chk("s5_faddr", fault_addr, 32'h8000_0000);
        adv(32'h8000_0000);
        chk("s5_pf_req", {31'b0, imem_req}, 32'd1);
        chk("s5_pf_addr", imem_addr, 32'h8000_0004);
        nreset = 1'b0;
        #1;
        chk("s5_async_rst_req", {31'b0, imem_req}, 32'd0);

        // Misaligned PC
        mem_hang = 0; mem_wait = 0;
        do_reset(32'h8000_0002, 0);
        adv(32'h8000_0002);
        chk("s6_req", {31'b0, imem_req}, 32'd0);
        chk("s6_valid", {31'b0, instr_valid}, 32'd1);
        chk("s6_bus", instr_bus, NOP);
        chk("s6_fault", {31'b0, fetch_fault}, 32'd1);
        chk("s6_faddr", fault_addr, 32'h8000_0002);
        adv(32'h8000_0002);
        chk("s6_req_c2", {31'b0, imem_req}, 32'd0);

        // Wrap of pc_in+4
        do_reset(32'hFFFF_FFFC, 0);
        adv(32'hFFFF_FFFC);
        chk("s7_req_addr", imem_addr, 32'hFFFF_FFFC);
        adv(32'hFFFF_FFFC);
        chk("s7_bus", instr_bus, 32'hA5A5_3C3F);
        adv(32'hFFFF_FFFC);
        chk("s7_pf_req", {31'b0, imem_req}, 32'd1);
        chk("s7_pf_addr", imem_addr, 32'h0000_0000);
        adv(32'h0000_0000);
        chk("s7_wrap_valid", {31'b0, instr_valid}, 32'd1);
        chk("s7_wrap_bus", instr_bus, 32'h5A5A_C3C3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
